matrix_core_seq: RTL and testbench
==================================

# matrix_core_seq

Job sequencer for the matrix core. Each job is started by a single `start` pulse with a dimension `dim`. The sequencer then:
- streams `dim*dim` weight beats and `dim` vector beats from the upstream operand stream into the core's sink port;
- pulses the core's compute strobe;
- drains `dim` result beats from the core's source port to the writeback stream.

It sits between the operand fetch unit and `matrix_core`, and is the only master of the core's handshake ports.

## Interface
- `DATA_WIDTH`, default `constants::DATA_WIDTH`: operand/result beat width.
- `MAX_DIM`, default 8: largest legal `dim`.
- `DIM_W`, default `$clog2(MAX_DIM+1)`: width of `dim`.
- `CNT_W`, default `$clog2(MAX_DIM*MAX_DIM+1)`: width of the beat counter.

Ports:
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  job request, sampled only in IDLE.
- `dim`  in  `DIM_W`  matrix dimension, sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a job completes.
- `err`  out  1  one-cycle pulse when `start` arrives with an illegal `dim`.
- `in_vld`, `in_rdy`, `in_data`  in/out/in  1/1/`DATA_WIDTH`  upstream operand stream.
- `core_vld`, `core_rdy`, `core_data`  out/in/out  1/1/`DATA_WIDTH`  core sink port.
- `core_sel`  out  2  beat type: 0 = weight, 1 = vector; 2 and 3 are reserved and never driven.
- `core_go`  out  1  one-cycle compute strobe.
- `core_res_vld`, `core_res_rdy`, `core_res_data`  in/out/in  1/1/`DATA_WIDTH`  core result port.
- `out_vld`, `out_rdy`, `out_data`  out/in/out  1/1/`DATA_WIDTH`  writeback stream.

## Operation
States: IDLE, LOAD_W, LOAD_V, FIRE, DRAIN.

- **IDLE**
  - `start` with 1 ≤ `dim` ≤ `MAX_DIM`: latch `dim`, clear `cnt`, go to LOAD_W.
  - `start` with `dim` = 0 or `dim` > `MAX_DIM`: pulse `err` next cycle, stay in IDLE.
  - `start` in any other state is ignored (no `err`).
- **LOAD_W**
  - Pass-through: `core_vld = in_vld`, `in_rdy = core_rdy`, `core_data = in_data`, `core_sel = 0`.
  - A beat transfers when `core_vld & core_rdy`; each transfer increments `cnt`.
  - On the transfer that makes `cnt = dim*dim`: go to LOAD_V and clear `cnt`.
- **LOAD_V**
  - Same pass-through with `core_sel = 1`.
  - After `dim` transfers: go to FIRE.
- **FIRE**
  - Lasts exactly one cycle with `core_go = 1`; then go to DRAIN and clear `cnt`.
- **DRAIN**
  - `out_vld = core_res_vld`, `core_res_rdy = out_rdy`, `out_data = core_res_data`.
  - After `dim` transfers: go to IDLE and pulse `done`.
- **Outside the active states**
  - `in_rdy`, `core_vld`, `core_res_rdy` and `out_vld` are forced to 0.
  - `core_data` and `out_data` are don't-care, but are driven from the pass-through.
- **Arithmetic**
  - `dim*dim` is computed once at latch time into a `CNT_W`-bit register.
  - `cnt` is `CNT_W` bits and never exceeds the target, so it cannot wrap.
- **No buffering**: the sequencer holds no data; the handshake is purely combinational gating of upstream and core signals.

## Timing
- **Reset values**: state = IDLE; `busy`, `done`, `err`, `core_go`, `core_vld`, `in_rdy`, `core_res_rdy`, `out_vld` = 0; `core_sel` = 0; `cnt` = 0.
- **Reset mid-job**: an asserted `rst` returns to IDLE on the next edge. No `done` is issued and partially loaded core state is abandoned; the next job reloads everything.
- **Job start**: `start` sampled at edge T puts the block in LOAD_W from T+1, so the first beat can transfer in cycle T+1.
- **Stalls**: a beat transfers only in a cycle where both valid and ready are high. Stalls on either side are unbounded, with no timeout.
- **State transitions**: the last-beat transfer and the state change occur on the same edge.
  - LOAD_W → LOAD_V is zero-bubble: the first vector beat can transfer in the cycle right after the last weight beat.
  - `core_go` is asserted in the cycle after the last vector beat.
- **Results during FIRE**: a `core_res_vld` arriving in the FIRE cycle is not accepted until DRAIN.
- **Job completion**:
  - `done` is high in the cycle after the final result transfer, and the state is IDLE in that same cycle.
  - `busy` drops to 0 in the `done` cycle.
  - A `start` in the `done` cycle is accepted.
- **Minimum job latency** with all readies held high: `dim*dim + dim + 1 + dim` cycles.

## Structure
- The `constants` package gains:
  - `DATA_WIDTH` (already present);
  - `MAX_DIM`;
  - `typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_LOAD_V, S_FIRE, S_DRAIN} seq_state_t`;
  - `localparam SEL_WEIGHT = 2'd0`, `SEL_VECTOR = 2'd1`.
- There is one natural sub-module, `beat_counter`: load, increment-on-fire, and a `last` flag comparing against the latched target. LOAD_W, LOAD_V and DRAIN all reuse it.

## Test plan
1. **Minimum job**: `dim = 2`, all readies high, a stream of 6 operands then 2 results. Expect 4 beats with `core_sel = 0`, then 2 with `core_sel = 1`, `core_go` pulsed once, 2 beats out, and `done` 9 cycles after the first LOAD_W beat.
2. **Backpressure**: `dim = 3` with `core_rdy` toggled every other cycle and `out_rdy` low for 5 cycles mid-drain. Expect exactly 9 + 3 + 3 transfers, no dropped or duplicated data (check against a scoreboard), and a single `done`.
3. **Illegal `dim`**: `start` with `dim = 0`, then with `dim = MAX_DIM + 1`. Expect `err` pulsed each time, `busy` staying 0, and no handshake activity.
4. **`start` while busy**: a `start` pulse during LOAD_V is ignored. The current job completes normally with no `err`.
5. **Reset mid-job**: `rst` asserted during DRAIN after 1 of 4 results. Next cycle, the block is in IDLE with all outputs at reset values and no `done`. A following `dim = 1` job then completes in 4 cycles.
6. **Back-to-back jobs**: `start` asserted in the `done` cycle. The second job's first beat transfers one cycle later.

Source files
------------

// File: rtl/constants.sv
// Shared constants and types for the matrix core and its job sequencer.
package constants;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned MAX_DIM    = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_V,
        S_FIRE,
        S_DRAIN
    } seq_state_t;

    localparam logic [1:0] SEL_WEIGHT = 2'd0;
    localparam logic [1:0] SEL_VECTOR = 2'd1;

endpackage

// File: rtl/matrix_core_seq_beat_counter.sv
// Beat counter shared by the load and drain phases; wraps to zero on the last beat.
module beat_counter #(
    parameter int unsigned CNT_W = 7
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic [CNT_W-1:0] i_target,
    output logic             o_last
);

    logic [CNT_W-1:0] r_cnt;

    assign o_last = i_inc && ((r_cnt + CNT_W'(1)) == i_target);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr || o_last) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/matrix_core_seq.sv
// Job sequencer: streams weights and vector into the matrix core, fires it, drains results.
module matrix_core_seq
    import constants::*;
#(
    parameter int unsigned DATA_WIDTH = constants::DATA_WIDTH,
    parameter int unsigned MAX_DIM    = 8,
    parameter int unsigned DIM_W      = $clog2(MAX_DIM + 1),
    parameter int unsigned CNT_W      = $clog2(MAX_DIM * MAX_DIM + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIM_W-1:0]      dim,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  core_vld,
    input  logic                  core_rdy,
    output logic [DATA_WIDTH-1:0] core_data,
    output logic [1:0]            core_sel,
    output logic                  core_go,
    input  logic                  core_res_vld,
    output logic                  core_res_rdy,
    input  logic [DATA_WIDTH-1:0] core_res_data,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [DATA_WIDTH-1:0] out_data
);

    seq_state_t       r_state, w_state_next;
    logic [DIM_W-1:0] r_dim;
    logic [CNT_W-1:0] r_dim_sq;
    logic             r_done, r_err;
    logic             w_legal, w_inc, w_clr, w_last;
    logic [CNT_W-1:0] w_target;

    assign w_legal  = (dim != '0) && (32'(dim) <= MAX_DIM);
    assign w_target = (r_state == S_LOAD_W) ? r_dim_sq : CNT_W'(r_dim);
    assign w_clr    = (r_state == S_IDLE) || (r_state == S_FIRE);

    beat_counter #(
        .CNT_W (CNT_W)
    ) u_beat_counter (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_clr    (w_clr),
        .i_inc    (w_inc),
        .i_target (w_target),
        .o_last   (w_last)
    );

    always_comb begin
        w_state_next = r_state;
        in_rdy       = 1'b0;
        core_vld     = 1'b0;
        core_sel     = SEL_WEIGHT;
        core_res_rdy = 1'b0;
        out_vld      = 1'b0;
        w_inc        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start && w_legal) w_state_next = S_LOAD_W;
            end
            S_LOAD_W: begin
                core_vld = in_vld;
                in_rdy   = core_rdy;
                w_inc    = in_vld && core_rdy;
                if (w_last) w_state_next = S_LOAD_V;
            end
            S_LOAD_V: begin
                core_vld = in_vld;
                in_rdy   = core_rdy;
                core_sel = SEL_VECTOR;
                w_inc    = in_vld && core_rdy;
                if (w_last) w_state_next = S_FIRE;
            end
            S_FIRE: begin
                w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                out_vld      = core_res_vld;
                core_res_rdy = out_rdy;
                w_inc        = core_res_vld && out_rdy;
                if (w_last) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_dim    <= '0;
            r_dim_sq <= '0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (r_state == S_DRAIN) && w_last;
            r_err   <= (r_state == S_IDLE) && start && !w_legal;
            if ((r_state == S_IDLE) && start && w_legal) begin
                r_dim    <= dim;
                r_dim_sq <= CNT_W'(dim) * CNT_W'(dim);
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign err       = r_err;
    assign core_go   = (r_state == S_FIRE);
    assign core_data = in_data;
    assign out_data  = core_res_data;

endmodule

// File: tb/tb_matrix_core_seq.sv
// Directed bench for matrix_core_seq: the bench plays upstream, core and writeback roles.
module tb_matrix_core_seq;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst, start, busy, done, err;
    logic [3:0]    dim;
    logic          in_vld, in_rdy, core_vld, core_rdy, core_go;
    logic          core_res_vld, core_res_rdy, out_vld, out_rdy;
    logic [DW-1:0] in_data, core_data, core_res_data, out_data;
    logic [1:0]    core_sel;

    int n_checks = 0;
    int n_fail   = 0;

    matrix_core_seq dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .dim           (dim),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .in_vld        (in_vld),
        .in_rdy        (in_rdy),
        .in_data       (in_data),
        .core_vld      (core_vld),
        .core_rdy      (core_rdy),
        .core_data     (core_data),
        .core_sel      (core_sel),
        .core_go       (core_go),
        .core_res_vld  (core_res_vld),
        .core_res_rdy  (core_res_rdy),
        .core_res_data (core_res_data),
        .out_vld       (out_vld),
        .out_rdy       (out_rdy),
        .out_data      (out_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Handshake inputs held high so any leak through the gating is visible.
    task automatic idle_inputs();
        start         = 1'b0;
        dim           = '0;
        in_vld        = 1'b1;
        in_data       = 32'hdead_beef;
        core_rdy      = 1'b1;
        core_res_vld  = 1'b1;
        core_res_data = 32'hcafe_f00d;
        out_rdy       = 1'b1;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_in_rdy"}, 32'(in_rdy), 0);
        check_eq({tag, "_core_vld"}, 32'(core_vld), 0);
        check_eq({tag, "_res_rdy"}, 32'(core_res_rdy), 0);
        check_eq({tag, "_out_vld"}, 32'(out_vld), 0);
        check_eq({tag, "_core_go"}, 32'(core_go), 0);
        check_eq({tag, "_core_sel"}, 32'(core_sel), 0);
    endtask

    // phase model: 0 weights, 1 vector, 2 fire, 3 drain
    task automatic run_job(input int d, input int job, input bit rdy_toggle, input int stall_at,
                           input int abort_at, input bit start_in_v, input int exp_cycles);
        int phase = 0;
        int wc = 0, vc = 0, oc = 0, stall_cnt = 0;
        bit sent_start = 1'b0;
        bit stalled;
        start = 1'b1;
        dim   = 4'(d);
        step();
        start = 1'b0;
        dim   = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (abort_at >= 0 && phase == 3 && oc == abort_at) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                idle_inputs();
                #1;
                check_quiet("rst_mid");
                check_eq("rst_mid_done", 32'(done), 0);
                check_eq("rst_mid_err", 32'(err), 0);
                step();
                check_eq("rst_after_done", 32'(done), 0);
                check_quiet("rst_after");
                return;
            end
            stalled       = (stall_at >= 0) && (oc == stall_at) && (stall_cnt < 5);
            in_vld        = 1'b1;
            in_data       = 32'(job * 256 + wc + vc);
            core_rdy      = rdy_toggle ? ((cyc % 2) == 0) : 1'b1;
            core_res_vld  = (phase >= 2);
            core_res_data = 32'(32'ha0 + job * 16 + oc);
            out_rdy       = !stalled;
            if (stalled && phase == 3) stall_cnt++;
            if (start_in_v && phase == 1 && !sent_start) begin
                start      = 1'b1;
                sent_start = 1'b1;
            end
            #1;
            check_eq("busy", 32'(busy), 1);
            check_eq("done_early", 32'(done), 0);
            check_eq("err_quiet", 32'(err), 0);
            check_eq("core_go", 32'(core_go), 32'(phase == 2));
            check_eq("core_sel", 32'(core_sel), 32'(phase == 1));
            check_eq("in_rdy", 32'(in_rdy), 32'((phase < 2) && core_rdy));
            check_eq("core_vld", 32'(core_vld), 32'(phase < 2));
            check_eq("out_vld", 32'(out_vld), 32'(phase == 3));
            check_eq("res_rdy", 32'(core_res_rdy), 32'((phase == 3) && out_rdy));
            if (phase < 2 && core_rdy) begin
                check_eq("core_data", core_data, 32'(job * 256 + wc + vc));
                if (phase == 0) wc++;
                else vc++;
            end
            if (phase == 3 && out_rdy) begin
                check_eq("out_data", out_data, 32'(32'ha0 + job * 16 + oc));
                oc++;
            end
            step();
            start = 1'b0;
            if (phase == 0 && wc == d * d) phase = 1;
            else if (phase == 1 && vc == d) phase = 2;
            else if (phase == 2) phase = 3;
            else if (phase == 3 && oc == d) begin
                check_eq("done", 32'(done), 1);
                check_eq("done_busy", 32'(busy), 0);
                check_eq("done_err", 32'(err), 0);
                check_eq("beats_w", 32'(wc), 32'(d * d));
                if (exp_cycles >= 0) check_eq("latency", 32'(cyc + 1), 32'(exp_cycles));
                return;
            end
        end
        check_eq("timeout", 0, 1);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        check_quiet("reset");
        check_eq("reset_done", 32'(done), 0);
        check_eq("reset_err", 32'(err), 0);
        rst = 1'b0;
        step();
        check_quiet("idle");

        // Minimum job, dim=2: 4 weights, 2 vectors, fire, 2 results; done 9 cycles after beat 1
        run_job(2, 1, 1'b0, -1, -1, 1'b0, 9);
        idle_inputs();
        step();
        check_eq("post_done", 32'(done), 0);
        check_quiet("post1");

        // Backpressure: dim=3, core_rdy toggling, out_rdy low 5 cycles after first result
        run_job(3, 2, 1'b1, 1, -1, 1'b0, -1);
        idle_inputs();
        step();

        // Illegal dim: 0 then MAX_DIM+1
        start = 1'b1;
        dim   = 4'd0;
        step();
        start = 1'b0;
        check_eq("err_dim0", 32'(err), 1);
        check_quiet("ill0");
        step();
        check_eq("err_dim0_pulse", 32'(err), 0);
        start = 1'b1;
        dim   = 4'd9;
        step();
        start = 1'b0;
        check_eq("err_dim9", 32'(err), 1);
        check_quiet("ill9");
        step();
        check_eq("err_dim9_pulse", 32'(err), 0);
        check_quiet("ill9b");

        // start (with illegal dim) during LOAD_V is ignored; 9+3+1+3 cycles
        run_job(3, 3, 1'b0, -1, -1, 1'b1, 16);
        idle_inputs();
        step();

        // Reset during DRAIN after 1 of 4 results, then a dim=1 job in 4 cycles
        run_job(4, 4, 1'b0, -1, 1, 1'b0, -1);
        run_job(1, 5, 1'b0, -1, -1, 1'b0, 4);
        idle_inputs();
        step();

        // Back-to-back: second start in the done cycle of the first
        run_job(2, 6, 1'b0, -1, -1, 1'b0, 9);
        run_job(2, 7, 1'b0, -1, -1, 1'b0, 9);
        idle_inputs();
        step();
        check_quiet("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
